// File: rtl/gpio_in_edge_irq_if.sv
// ---------------------------------------------------------------------------
// gpio_in_edge_irq_if
// Avalon-MM slave bus bundle for the edge-capturing input PIO.
//   address    : register word select (2 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe, qualified by chipselect
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data (driven by the slave)
// Modports: master (interconnect / testbench side), slave (PIO side).
// ---------------------------------------------------------------------------
interface gpio_in_edge_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/gpio_in_edge_irq.sv
// ---------------------------------------------------------------------------
// gpio_in_edge_irq
// Parametrised Avalon-MM input PIO: synchronises WIDTH asynchronous status
// lines, captures selected edges per bit (write-1-to-clear), masks them and
// raises an interrupt.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : Avalon-MM slave (address, chipselect, write_n, writedata,
//             readdata)
//   in_port : WIDTH asynchronous external inputs
//   irq     : active-high interrupt request (from registers only)
// Register map (word address):
//   0 DATA        RO  synchronised input
//   1 reserved        reads 0, writes ignored
//   2 IRQMASK     RW
//   3 EDGECAPTURE R/W1C
// ---------------------------------------------------------------------------
module gpio_in_edge_irq #(
  parameter int WIDTH       = 1,  // 1..32
  parameter int SYNC_STAGES = 2,  // 2..4
  parameter int EDGE_TYPE   = 0,  // 0 rising, 1 falling, 2 any
  parameter int IRQ_MODE    = 1   // 0 level, 1 edge
) (
  input  logic               clk,
  input  logic               reset_n,
  gpio_in_edge_irq_if.slave  bus,
  input  logic [WIDTH-1:0]   in_port,
  output logic               irq
);

  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

  // Synchroniser chain; element 0 samples in_port, the top element is sync_q.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain_q;
  logic [WIDTH-1:0]                  sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [2:0]                        prime_cnt_q;
  logic [2:0]                        prime_cnt_d;
  logic                              primed;
  logic [WIDTH-1:0]                  irqmask_q;
  logic [WIDTH-1:0]                  irqmask_d;
  logic [WIDTH-1:0]                  edgecapture_q;
  logic [WIDTH-1:0]                  edgecapture_d;
  logic [31:0]                       readdata_q;
  logic [31:0]                       readdata_d;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] det_sel;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] ec_clr;

  assign sync_q = sync_chain_q[SYNC_STAGES-1];
  assign wr_en  = bus.chipselect & ~bus.write_n;
  assign wdata  = bus.writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_unused_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^bus.writedata[31:WIDTH];
    end
  endgenerate

  // Edge detection is held off until the synchroniser and prev have been
  // filled with real input samples, so a line that is already high when
  // reset releases does not look like a rising edge.
  assign primed      = (prime_cnt_q == PRIME_MAX);
  assign prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + 3'd1;

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign det_sel = rise;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign det_sel = fall;
    end else begin : g_any
      assign det_sel = rise | fall;
    end
  endgenerate

  assign det    = primed ? det_sel : '0;
  assign ec_clr = (wr_en && bus.address == 2'd3) ? wdata : '0;

  // A newly detected edge wins over a simultaneous clear of the same bit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ec
      assign edgecapture_d[gi] = det[gi] | (edgecapture_q[gi] & ~ec_clr[gi]);
    end
  endgenerate

  assign irqmask_d = (wr_en && bus.address == 2'd2) ? wdata : irqmask_q;

  // Read mux samples the pre-update registers, so a read of EDGECAPTURE in
  // the same cycle as a clear returns the value before the clear.
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      2'd0:    readdata_d[WIDTH-1:0] = sync_q;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgecapture_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_chain_q  <= '0;
      prev_q        <= '0;
      prime_cnt_q   <= '0;
      irqmask_q     <= '0;
      edgecapture_q <= '0;
      readdata_q    <= '0;
    end else begin
      sync_chain_q  <= {sync_chain_q[SYNC_STAGES-2:0], in_port};
      prev_q        <= sync_q;
      prime_cnt_q   <= prime_cnt_d;
      irqmask_q     <= irqmask_d;
      edgecapture_q <= edgecapture_d;
      readdata_q    <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;

  generate
    if (IRQ_MODE == 1) begin : g_irq_edge
      assign irq = |(edgecapture_q & irqmask_q);
    end else begin : g_irq_level
      assign irq = |(sync_q & irqmask_q);
    end
  endgenerate

endmodule

// File: tb/tb_gpio_in_edge_irq.sv
// ---------------------------------------------------------------------------
// tb_gpio_in_edge_irq
// Two instances share one bus (separate chipselects and in_port):
//   A: WIDTH=4, SYNC_STAGES=2, EDGE_TYPE=0 (rising), IRQ_MODE=1 (edge)
//   B: WIDTH=4, SYNC_STAGES=2, EDGE_TYPE=2 (any),    IRQ_MODE=0 (level)
// Driver pushes hand-computed expectations into a scoreboard queue; a monitor
// pops and compares one clock later when the registered readdata is valid.
// ---------------------------------------------------------------------------
module tb_gpio_in_edge_irq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        cs_a = 1'b0;
  logic        cs_b = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_a = 4'hF;
  logic [3:0]  in_b = 4'h0;
  logic        irq_a;
  logic        irq_b;

  always #5 clk = ~clk;

  gpio_in_edge_irq_if bus_a ();
  gpio_in_edge_irq_if bus_b ();

  assign bus_a.address    = address;
  assign bus_a.chipselect = cs_a;
  assign bus_a.write_n    = write_n;
  assign bus_a.writedata  = writedata;
  assign bus_b.address    = address;
  assign bus_b.chipselect = cs_b;
  assign bus_b.write_n    = write_n;
  assign bus_b.writedata  = writedata;

  gpio_in_edge_irq #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a),
    .in_port (in_a),
    .irq     (irq_a)
  );

  gpio_in_edge_irq #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_MODE(0)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b),
    .in_port (in_b),
    .irq     (irq_b)
  );

  typedef struct {
    int          dut;
    logic [31:0] exp_rd;
    bit          chk_irq;
    logic        exp_irq;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic rd_issue = 1'b0;
  logic rd_valid = 1'b0;

  always @(posedge clk) rd_valid <= rd_issue;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("[TB] %s: 0x%08h ok", name, act);
    end
  endtask

  // Monitor: readdata/irq are valid one clock after the read was issued.
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL sb_underflow: got a read with no expectation, expected one queued");
      end else begin
        e = sb.pop_front();
        check32({e.name, "_rd"}, (e.dut == 0) ? bus_a.readdata : bus_b.readdata, e.exp_rd);
        if (e.chk_irq)
          check32({e.name, "_irq"}, {31'd0, (e.dut == 0) ? irq_a : irq_b}, {31'd0, e.exp_irq});
      end
    end
  end

  // One bus cycle starting and ending on a falling edge.
  task automatic bus_op(input int dut, input bit wr, input logic [1:0] a, input logic [31:0] d,
                        input bit chk, input logic [31:0] exp_rd, input bit chk_irq,
                        input logic exp_irq, input string name);
    address   = a;
    writedata = d;
    write_n   = ~wr;
    cs_a      = (dut == 0);
    cs_b      = (dut == 1);
    if (chk) sb.push_back('{dut, exp_rd, chk_irq, exp_irq, name});
    rd_issue  = chk;
    @(negedge clk);
    cs_a     = 1'b0;
    cs_b     = 1'b0;
    write_n  = 1'b1;
    rd_issue = 1'b0;
  endtask

  task automatic rd(input int dut, input logic [1:0] a, input logic [31:0] exp_rd,
                    input logic exp_irq, input string name);
    bus_op(dut, 1'b0, a, 32'd0, 1'b1, exp_rd, 1'b1, exp_irq, name);
  endtask

  task automatic wr(input int dut, input logic [1:0] a, input logic [31:0] d);
    bus_op(dut, 1'b1, a, d, 1'b0, 32'd0, 1'b0, 1'b0, "wr");
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with A's input held high.
    #12;
    check32("rst_rd_a", bus_a.readdata, 32'd0);
    check32("rst_irq_a", {31'd0, irq_a}, 32'd0);
    check32("rst_rd_b", bus_b.readdata, 32'd0);
    check32("rst_irq_b", {31'd0, irq_b}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(6);
    rd(0, 2'd0, 32'hF, 1'b0, "prime_data_a");
    rd(0, 2'd3, 32'h0, 1'b0, "prime_ec_a");

    // Rising edge on bit 0, latency and clear.
    in_a = 4'h0;
    tick(4);
    wr(0, 2'd2, 32'h5);
    rd(0, 2'd2, 32'h5, 1'b0, "mask_a");
    rd(0, 2'd3, 32'h0, 1'b0, "ec_idle_a");
    in_a = 4'h1;
    rd(0, 2'd3, 32'h0, 1'b0, "lat0_a");
    rd(0, 2'd3, 32'h0, 1'b0, "lat1_a");
    rd(0, 2'd3, 32'h0, 1'b1, "lat2_a");
    rd(0, 2'd3, 32'h1, 1'b1, "lat3_a");
    bus_op(0, 1'b1, 2'd3, 32'h1, 1'b1, 32'h1, 1'b1, 1'b0, "clr_preread_a");
    rd(0, 2'd3, 32'h0, 1'b0, "cleared_a");

    // Set-beats-clear on bit 0; plain clear on bit 1.
    in_a = 4'h3;
    tick(4);
    in_a = 4'h2;
    tick(4);
    rd(0, 2'd3, 32'h2, 1'b0, "bit1_set_a");
    in_a = 4'h3;
    tick(2);
    bus_op(0, 1'b1, 2'd3, 32'h3, 1'b1, 32'h2, 1'b1, 1'b1, "set_vs_clr_a");
    rd(0, 2'd3, 32'h1, 1'b1, "after_setclr_a");

    // B: any-edge capture of a 3-clock pulse on bit 2, mask 0.
    in_b = 4'h4;
    rd(1, 2'd3, 32'h0, 1'b0, "pulse0_b");
    rd(1, 2'd3, 32'h0, 1'b0, "pulse1_b");
    rd(1, 2'd3, 32'h0, 1'b0, "pulse2_b");
    in_b = 4'h0;
    bus_op(1, 1'b1, 2'd3, 32'h4, 1'b1, 32'h4, 1'b1, 1'b0, "rise_cap_b");
    rd(1, 2'd3, 32'h0, 1'b0, "pulse4_b");
    rd(1, 2'd3, 32'h0, 1'b0, "pulse5_b");
    rd(1, 2'd3, 32'h4, 1'b0, "fall_cap_b");

    // B: level irq from synchronised data.
    wr(1, 2'd2, 32'h8);
    in_b = 4'h8;
    rd(1, 2'd0, 32'h0, 1'b0, "lvl0_b");
    rd(1, 2'd0, 32'h0, 1'b1, "lvl1_b");
    rd(1, 2'd0, 32'h8, 1'b1, "lvl2_b");
    wr(1, 2'd0, 32'hFFFF_FFFF);
    wr(1, 2'd1, 32'hFFFF_FFFF);
    rd(1, 2'd0, 32'h8, 1'b1, "data_ro_b");
    rd(1, 2'd1, 32'h0, 1'b1, "resv_b");
    rd(1, 2'd2, 32'h8, 1'b1, "mask_kept_b");
    in_b = 4'h0;
    rd(1, 2'd0, 32'h8, 1'b1, "lvlf0_b");
    rd(1, 2'd0, 32'h8, 1'b0, "lvlf1_b");
    rd(1, 2'd0, 32'h0, 1'b0, "lvlf2_b");

    // A: all bits captured, then reset mid-operation.
    wr(0, 2'd2, 32'hF);
    in_a = 4'h0;
    tick(4);
    in_a = 4'hF;
    tick(4);
    rd(0, 2'd3, 32'hF, 1'b1, "ec_full_a");
    rd(0, 2'd2, 32'hF, 1'b1, "mask_full_a");
    #1 reset_n = 1'b0;
    #1;
    check32("mid_rst_rd_a", bus_a.readdata, 32'd0);
    check32("mid_rst_irq_a", {31'd0, irq_a}, 32'd0);
    check32("mid_rst_rd_b", bus_b.readdata, 32'd0);
    tick(2);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) rd(0, 2'd3, 32'h0, 1'b0, $sformatf("no_spur%0d_a", i));
    rd(0, 2'd0, 32'hF, 1'b0, "post_rst_data_a");
    rd(0, 2'd2, 32'h0, 1'b0, "post_rst_mask_a");
    rd(1, 2'd2, 32'h0, 1'b0, "post_rst_mask_b");
    rd(1, 2'd3, 32'h0, 1'b0, "post_rst_ec_b");

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL sb_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
